// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: shares one NOR SR latch between NREQ requesters as mutually exclusive, timed S/R pulses.
// Latency: grant and first S/R cycle one clk after the IDLE sample; op period PULSE_W+GAP_W+2 clks.
// Backpressure: requests are level-held until granted, ignored while busy; SR_LATCH_CTRL_VERIFY_EN adds a sticky Q check (err).
module sr_latch_ctrl #(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] set_req,
    input  logic [NREQ-1:0] rst_req,
    input  logic            q,
    output logic [NREQ-1:0] grant,
    output logic [OW-1:0]   owner,
    output logic            s,
    output logic            r,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            op_rst, op_nxt;
    logic [OW-1:0]   rr_ptr, rr_nxt;
    logic [OW-1:0]   owner_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic            s_nxt, r_nxt;
    logic            chk_q;

    logic [NREQ-1:0] req_act;
    logic [OW-1:0]   idx;
    logic [OW-1:0]   pick;
    logic            pick_vld;

    // Scan from the highest rotation down so the first active index at/after rr_ptr wins.
    always_comb begin
        req_act  = set_req | rst_req;
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = OW'((int'(rr_ptr) + k) % NREQ);
            if (req_act[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_rst;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        grant_nxt = '0;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        chk_q     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt       = ST_PULSE;
                    cnt_nxt         = '0;
                    owner_nxt       = pick;
                    op_nxt          = rst_req[pick];
                    grant_nxt[pick] = 1'b1;
                    s_nxt           = ~rst_req[pick];
                    r_nxt           = rst_req[pick];
                    rr_nxt          = (pick == OW'(NREQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt == CW'(PULSE_W - 1)) begin
                    cnt_nxt   = '0;
                    chk_q     = 1'b1;
                    state_nxt = (GAP_W > 0) ? ST_GAP : ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    s_nxt   = ~op_rst;
                    r_nxt   = op_rst;
                end
            end
            ST_GAP: begin
                if (cnt == CW'(GAP_W - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_rst <= 1'b0;
            owner  <= '0;
            rr_ptr <= '0;
            grant  <= '0;
            s      <= 1'b0;
            r      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_rst <= op_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_nxt;
            grant  <= grant_nxt;
            s      <= s_nxt;
            r      <= r_nxt;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

`ifdef SR_LATCH_CTRL_VERIFY_EN
    // q is checked on the edge that ends the last pulse cycle, after the latch has had the full pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (chk_q && (q != ~op_rst)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_sig;
    assign unused_sig = q ^ chk_q;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: behavioural NOR latch on s/r, grant scoreboard, directed tests and random request traffic.
module tb_sr_latch_ctrl;

    localparam int NREQ    = 4;
    localparam int PULSE_W = 2;
    localparam int GAP_W   = 1;
    localparam int OW      = 2;
    localparam int PERIOD  = PULSE_W + GAP_W + 2;
`ifdef SR_LATCH_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] set_req = '0;
    logic [NREQ-1:0] rst_req = '0;
    logic            q;
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   owner;
    logic            s, r, busy, done, err;

    logic q_lat    = 1'b0;
    logic force_q0 = 1'b0;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [OW-1:0]   own;
        bit              op_rst;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en  = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    sr_latch_ctrl #(.NREQ(NREQ), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .rst_req(rst_req), .q(q),
        .grant(grant), .owner(owner), .s(s), .r(r), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(*) begin
        if (s && !r) q_lat = 1'b1;
        else if (r && !s) q_lat = 1'b0;
    end
    assign q = force_q0 ? 1'b0 : q_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g, input int own, input bit op);
        exp_t e;
        e.g = g; e.own = OW'(own); e.op_rst = op;
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (grant != 0) begin
                at = cyc;
                break;
            end
        end
        check("grant_seen", 32'(|grant), 1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: grant scoreboard, pulse width, done latency, S/R exclusion.
    int run_len    = 0;
    int since_gnt  = -1;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            run_len   = 0;
            since_gnt = -1;
        end else begin
            check("s_r_exclusive", 32'(s & r), 0);
            if (s | r) run_len++;
            else if (run_len != 0) begin
                check("pulse_width", run_len, PULSE_W);
                run_len = 0;
            end
            if (since_gnt >= 0) since_gnt++;
            if (grant != 0) begin
                since_gnt = 0;
                if (sb_en) begin
                    if (sb_q.size() == 0) check("unexpected_grant", 32'(grant), 0);
                    else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("sb_grant", 32'(grant), 32'(e.g));
                        check("sb_owner", 32'(owner), 32'(e.own));
                        check("sb_s", 32'(s), 32'(!e.op_rst));
                        check("sb_r", 32'(r), 32'(e.op_rst));
                    end
                end
            end
            if (done) begin
                if (since_gnt >= 0) check("done_latency", since_gnt, PULSE_W + GAP_W);
                since_gnt = -1;
            end
        end
    end

    initial begin
        int at, prev;
        logic s_seen;

        // Reset with every request asserted
        set_req = '1; rst_req = '1;
        repeat (2) @(negedge clk);
        check("rst_s", 32'(s), 0);
        check("rst_r", 32'(r), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_owner", 32'(owner), 0);
        set_req = '0; rst_req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single set, cycle by cycle
        set_req = 4'b0001; push(4'b0001, 0, 1'b0);
        @(negedge clk);
        check("one_grant", 32'(grant), 32'h1);
        check("one_s1", 32'(s), 1);
        check("one_r1", 32'(r), 0);
        check("one_busy", 32'(busy), 1);
        set_req = '0;
        @(negedge clk);
        check("one_s2", 32'(s), 1);
        check("one_grant_gone", 32'(grant), 0);
        @(negedge clk);
        check("one_gap_s", 32'(s), 0);
        check("one_gap_r", 32'(r), 0);
        check("one_gap_done", 32'(done), 0);
        @(negedge clk);
        check("one_done", 32'(done), 1);
        @(negedge clk);
        check("one_done_pulse", 32'(done), 0);
        check("one_idle", 32'(busy), 0);
        check("one_q", 32'(q), 1);

        // Round robin with all set requests held
        do_reset();
        set_req = 4'b1111;
        for (int i = 0; i < 5; i++) push(NREQ'(1) << (i % NREQ), i % NREQ, 1'b0);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(at);
            check("rr_grant", 32'(grant), 32'(1) << (i % NREQ));
            check("rr_owner", 32'(owner), i % NREQ);
            if (i > 0) check("rr_spacing", at - prev, PERIOD);
            prev = at;
            if (i == 4) set_req = '0;
        end
        wait_idle();

        // Set and reset both asserted: reset wins
        set_req = 4'b0100; rst_req = 4'b0100; push(4'b0100, 2, 1'b1);
        wait_grant(at);
        set_req = '0; rst_req = '0;
        s_seen = s;
        repeat (4) begin
            @(negedge clk);
            s_seen = s_seen | s;
        end
        check("conflict_no_s", 32'(s_seen), 0);
        check("conflict_q", 32'(q), 0);

        // Abort on the second pulse cycle, then re-arbitrate the held request
        wait_idle();
        set_req = 4'b0010; push(4'b0010, 1, 1'b0);
        wait_grant(at);
        @(negedge clk);
        check("abort_pulse2", 32'(s), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_s", 32'(s), 0);
        check("abort_r", 32'(r), 0);
        check("abort_busy", 32'(busy), 0);
        push(4'b0010, 1, 1'b0);
        rst = 1'b0;
        wait_grant(at);
        check("rearb_owner", 32'(owner), 1);
        set_req = '0;
        wait_idle();

        // Q mismatch during a SET pulse, then a good op
        set_req = 4'b0001; push(4'b0001, 0, 1'b0);
        wait_grant(at);
        force_q0 = 1'b1;
        set_req  = '0;
        wait_done();
        @(negedge clk);
        check("err_set", 32'(err), 32'(VERIFY));
        force_q0 = 1'b0;
        set_req = 4'b0001; push(4'b0001, 0, 1'b0);
        wait_grant(at);
        set_req = '0;
        wait_done();
        @(negedge clk);
        check("err_sticky", 32'(err), 32'(VERIFY));
        check("good_q", 32'(q), 1);
        do_reset();
        check("err_cleared", 32'(err), 0);

        // Random held-until-grant traffic
        sb_en = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    check("rnd_s", 32'(s), 32'(set_req[i] & ~rst_req[i]));
                    check("rnd_r", 32'(r), 32'(rst_req[i]));
                    check("rnd_owner", 32'(owner), i);
                    set_req[i] = 1'b0;
                    rst_req[i] = 1'b0;
                end
            end
            check("rnd_onehot", 32'($onehot0(grant)), 1);
            if (k < 400) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!set_req[i] && !rst_req[i] && !grant[i] && $urandom_range(3) == 0) begin
                        int op;
                        op = $urandom_range(2);
                        set_req[i] = (op != 1);
                        rst_req[i] = (op != 0);
                    end
                end
            end else if ((set_req | rst_req) == 0 && !busy) begin
                break;
            end
        end
        check("rnd_drained", 32'(set_req | rst_req), 0);
        wait_idle();
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
